// File: rtl/control_decode_stage_pkg.sv
// Shared types, opcode/funct3 constants and helpers for the RV32I decode stage.
package control_decode_stage_pkg;

    typedef enum logic [6:0] {
        OpcLoad   = 7'b0000011,
        OpcStore  = 7'b0100011,
        OpcOpImm  = 7'b0010011,
        OpcOp     = 7'b0110011,
        OpcBranch = 7'b1100011,
        OpcJal    = 7'b1101111,
        OpcJalr   = 7'b1100111,
        OpcLui    = 7'b0110111,
        OpcAuipc  = 7'b0010111
    } opcode_type_t;

    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [2:0] {RType, IType, SType, BType, UType, JType} instruction_type_t;

    typedef enum logic [1:0] {ResAlu, ResMem, ResPc4} result_select_t;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluMulDiv
    } alu_op_t;

    typedef struct packed {
        logic              reg_write;
        logic              alu_select;
        logic              dmem_write;
        result_select_t    result_select;
        logic              branch;
        logic              jump;
        alu_op_t           alu_op;
        logic [2:0]        funct3;
        instruction_type_t instruction_type;
    } ctrl_bundle_t;

    // alt is instr[30]; it selects SUB only for register-register ops.
    function automatic alu_op_t alu_op_from_funct(logic [2:0] funct3, logic alt, logic is_op);
        alu_op_t op;
        op = AluAdd;
        unique case (funct3)
            3'd0: op = (is_op && alt) ? AluSub : AluAdd;
            3'd1: op = AluSll;
            3'd2: op = AluSlt;
            3'd3: op = AluSltu;
            3'd4: op = AluXor;
            3'd5: op = alt ? AluSra : AluSrl;
            3'd6: op = AluOr;
            3'd7: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_decode_comb.sv
// Pure combinational RV32I decode: instruction -> control bundle, immediate, indices, illegal.
// Define CONTROL_DECODE_M_EXT_EN to accept the M-extension group on OP (funct7 = 7'b0000001).
module control_decode_comb
    import control_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_bundle_t    ctrl,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    always_comb begin
        ctrl                  = '0;
        ctrl.funct3           = funct3;
        ctrl.instruction_type = RType;
        ctrl.result_select    = ResAlu;
        ctrl.alu_op           = AluAdd;
        legal                 = 1'b0;
        // A low-bit pair other than 2'b11 never matches an opcode, so it falls to default.
        case (opcode)
            OpcLoad: begin
                ctrl.instruction_type = IType;
                ctrl.reg_write        = 1'b1;
                ctrl.alu_select       = 1'b1;
                ctrl.result_select    = ResMem;
                legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
            end
            OpcStore: begin
                ctrl.instruction_type = SType;
                ctrl.alu_select       = 1'b1;
                ctrl.dmem_write       = 1'b1;
                legal = funct3 inside {F3_SB, F3_SH, F3_SW};
            end
            OpcOpImm: begin
                ctrl.instruction_type = IType;
                ctrl.reg_write        = 1'b1;
                ctrl.alu_select       = 1'b1;
                ctrl.alu_op           = alu_op_from_funct(funct3, instr[30], 1'b0);
                if (funct3 == 3'd1)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'd5) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                     legal = 1'b1;
            end
            OpcOp: begin
                ctrl.instruction_type = RType;
                ctrl.reg_write        = 1'b1;
                ctrl.alu_op           = alu_op_from_funct(funct3, instr[30], 1'b1);
                case (funct7)
                    7'b0000000: legal = 1'b1;
                    7'b0100000: legal = (funct3 == 3'd0) || (funct3 == 3'd5);
`ifdef CONTROL_DECODE_M_EXT_EN
                    7'b0000001: begin
                        legal       = 1'b1;
                        ctrl.alu_op = AluMulDiv;
                    end
`endif
                    default:    legal = 1'b0;
                endcase
            end
            OpcBranch: begin
                ctrl.instruction_type = BType;
                ctrl.branch           = 1'b1;
                ctrl.alu_op           = AluSub;
                legal = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
            end
            OpcJal, OpcJalr: begin
                ctrl.instruction_type = (opcode == OpcJal) ? JType : IType;
                ctrl.jump             = 1'b1;
                ctrl.reg_write        = 1'b1;
                ctrl.result_select    = ResPc4;
                legal = (opcode == OpcJal) || (funct3 == 3'b000);
            end
            OpcLui, OpcAuipc: begin
                ctrl.instruction_type = UType;
                ctrl.reg_write        = 1'b1;
                ctrl.alu_select       = 1'b1;
                legal                 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries still flow but must not cause architectural side effects.
        if (!legal) begin
            ctrl.reg_write  = 1'b0;
            ctrl.dmem_write = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.jump       = 1'b0;
        end
    end

    assign illegal = !legal;

    always_comb begin
        imm32 = '0;
        case (ctrl.instruction_type)
            IType:   imm32 = {{20{instr[31]}}, instr[31:20]};
            SType:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BType:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            UType:   imm32 = {instr[31:12], 12'b0};
            JType:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                              1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/control_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and 1- or 2-entry output buffering.
// Define CONTROL_DECODE_M_EXT_EN to decode the M-extension OP group as legal MULDIV.
module control_decode_stage
    import control_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_bundle_t    out_ctrl,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam int unsigned ENTRY_W = $bits(ctrl_bundle_t) + 2 * XLEN + 16;

    ctrl_bundle_t       dec_ctrl;
    logic [XLEN-1:0]    dec_imm;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic [4:0]         dec_rd;
    logic               dec_illegal;
    logic [ENTRY_W-1:0] dec_entry;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] main_d;
    logic               main_valid_q;
    logic               main_valid_d;
    logic               in_fire;
    logic               out_fire;

    control_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    assign dec_entry = {dec_ctrl, dec_imm, dec_rs1, dec_rs2, dec_rd, in_pc, dec_illegal};
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign {out_ctrl, out_imm, out_rs1, out_rs2, out_rd, out_pc, out_illegal} = main_q;

    generate
        if (BUF_DEPTH == 1) begin : g_single
            logic started_q;

            assign in_ready = started_q && !flush && (!main_valid_q || out_ready);

            always_comb begin
                main_d       = main_q;
                main_valid_d = main_valid_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_d       = dec_entry;
                    main_valid_d = 1'b1;
                end else if (out_fire) begin
                    main_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) started_q <= 1'b0;
                else        started_q <= 1'b1;
            end
        end else begin : g_skid
            logic [ENTRY_W-1:0] skid_q;
            logic [ENTRY_W-1:0] skid_d;
            logic               skid_valid_q;
            logic               skid_valid_d;
            logic               ready_q;

            // in_ready comes straight from a flop so fetch never sees a path from out_ready.
            assign in_ready = ready_q && !flush;

            always_comb begin
                main_d       = main_q;
                main_valid_d = main_valid_q;
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (out_fire || !main_valid_q) begin
                    if (skid_valid_q) begin
                        main_d       = skid_q;
                        main_valid_d = 1'b1;
                        skid_valid_d = 1'b0;
                    end else if (in_fire) begin
                        main_d       = dec_entry;
                        main_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (in_fire) begin
                    skid_d       = dec_entry;
                    skid_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_q       <= '0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b0;
                end else begin
                    skid_q       <= skid_d;
                    skid_valid_q <= skid_valid_d;
                    ready_q      <= !skid_valid_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

endmodule

// File: tb/tb_control_decode_stage.sv
// Bench for control_decode_stage: directed steps plus random traffic against a queue-based model.
module tb_control_decode_stage;
    import control_decode_stage_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef CONTROL_DECODE_M_EXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef struct packed {
        ctrl_bundle_t    ctrl;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    ctrl_bundle_t    out_ctrl;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    int     errors = 0;
    int     checks = 0;
    entry_t q[$];
    bit     started = 1'b0;

    always #5 clk = ~clk;

    control_decode_stage #(
        .XLEN      (XLEN),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the ISA rules: field tables and shifted-signed arithmetic.
    function automatic entry_t model(input logic [31:0] i, input logic [XLEN-1:0] pc);
        entry_t           e;
        logic signed [31:0] s;
        logic signed [31:0] s20;
        logic signed [31:0] s25;
        logic signed [31:0] s31;
        logic [2:0]       f3;
        logic [6:0]       f7;
        bit               ok;
        alu_op_t          base [8];
        base = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};
        s   = i;
        s20 = s >>> 20;
        s25 = s >>> 25;
        s31 = s >>> 31;
        f3  = i[14:12];
        f7  = i[31:25];
        e   = '0;
        ok  = 1'b0;
        e.pc = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        e.ctrl.funct3 = f3;
        e.ctrl.instruction_type = RType;
        e.ctrl.alu_op = AluAdd;
        case (i[6:0])
            7'h03: begin
                e.ctrl.instruction_type = IType; e.ctrl.reg_write = 1; e.ctrl.alu_select = 1;
                e.ctrl.result_select = ResMem; ok = (f3 != 3) && (f3 < 6);
            end
            7'h23: begin
                e.ctrl.instruction_type = SType; e.ctrl.alu_select = 1; e.ctrl.dmem_write = 1;
                ok = f3 < 3;
            end
            7'h13: begin
                e.ctrl.instruction_type = IType; e.ctrl.reg_write = 1; e.ctrl.alu_select = 1;
                e.ctrl.alu_op = (f3 == 5 && f7[5]) ? AluSra : base[f3];
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            end
            7'h33: begin
                e.ctrl.reg_write = 1;
                e.ctrl.alu_op = (f3 == 0 && f7[5]) ? AluSub : (f3 == 5 && f7[5]) ? AluSra : base[f3];
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (MEXT && f7 == 1);
                if (MEXT && f7 == 1) e.ctrl.alu_op = AluMulDiv;
            end
            7'h63: begin
                e.ctrl.instruction_type = BType; e.ctrl.branch = 1; e.ctrl.alu_op = AluSub;
                ok = (f3 != 2) && (f3 != 3);
            end
            7'h6F, 7'h67: begin
                e.ctrl.instruction_type = (i[3]) ? JType : IType;
                e.ctrl.jump = 1; e.ctrl.reg_write = 1; e.ctrl.result_select = ResPc4;
                ok = i[3] || (f3 == 0);
            end
            7'h37, 7'h17: begin
                e.ctrl.instruction_type = UType; e.ctrl.reg_write = 1; e.ctrl.alu_select = 1;
                ok = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        case (e.ctrl.instruction_type)
            IType: e.imm = s20;
            SType: e.imm = (s25 << 5) | 32'(i[11:7]);
            BType: e.imm = (s31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                           | (32'(i[11:8]) << 1);
            UType: e.imm = i & 32'hFFFF_F000;
            JType: e.imm = (s31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                           | (32'(i[30:21]) << 1);
            default: e.imm = '0;
        endcase
        if (!ok) begin
            e.illegal = 1'b1;
            e.ctrl.reg_write = 0; e.ctrl.dmem_write = 0; e.ctrl.branch = 0; e.ctrl.jump = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int unsigned r;
        logic [6:0]  ops [10];
        ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
        i = $urandom;
        r = $urandom_range(0, 11);
        if (r < 10) i[6:0] = ops[r];
        if ($urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 2);
            i[31:25] = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'h01;
        end
        return i;
    endfunction

    // One clock: check and update the model at the falling edge, return 1 ns after the rising edge.
    task automatic cycle(output bit fired);
        entry_t got;
        bit     exp_ready;
        @(negedge clk);
        exp_ready = started && (q.size() < 2) && !flush;
        if (started) check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, q.size() != 0);
        got = {out_ctrl, out_imm, out_rs1, out_rs2, out_rd, out_pc, out_illegal};
        if (q.size() != 0) check("entry", got, q[0]);
        fired = in_valid && exp_ready;
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (flush) q.delete();
        if (fired) q.push_back(model(in_instr, in_pc));
        @(posedge clk);
        #1;
        started = 1'b1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bit f;
        f = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int n = 0; n < 20 && !f; n++) cycle(f);
        check("offer_taken", f, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit f;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10 && q.size() != 0; n++) cycle(f);
        check("drained", out_valid, 1'b0);
    endtask

    initial begin
        bit f;
        // Reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_imm", out_imm, '0);
        check("rst_out_ctrl", out_ctrl, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(f);
        check("rst_in_ready", in_ready, 1'b1);

        // LW x5,-4(x2): one cycle latency
        offer(32'hFFC12283, 32'h0000_1000);
        check("lw_valid", out_valid, 1'b1);
        check("lw_reg_write", out_ctrl.reg_write, 1'b1);
        check("lw_result_sel", out_ctrl.result_select, ResMem);
        check("lw_rd", out_rd, 5'd5);
        check("lw_rs1", out_rs1, 5'd2);
        check("lw_imm", out_imm, 32'hFFFF_FFFC);
        drain();

        // Four instructions with out_ready low for three cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093; in_pc = 32'h200; cycle(f);
        in_instr  = 32'h00A00113; in_pc = 32'h204; cycle(f);
        check("skid_full_in_ready", in_ready, 1'b0);
        in_instr  = 32'h002081B3; in_pc = 32'h208; cycle(f);
        out_ready = 1'b1;
        offer(32'h002081B3, 32'h208);
        offer(32'h40208233, 32'h20C);
        drain();

        // Flush with two held entries and an input on offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFC12283; in_pc = 32'h300; cycle(f);
        in_instr  = 32'h0020A023; in_pc = 32'h304; cycle(f);
        flush     = 1'b1;
        in_instr  = 32'h00100093; in_pc = 32'h308;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        cycle(f);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);

        // Illegal encodings
        out_ready = 1'b1;
        offer(32'h0000_0000, 32'h400);
        check("zero_illegal", out_illegal, 1'b1);
        check("zero_reg_write", out_ctrl.reg_write, 1'b0);
        offer(32'h0020B023, 32'h404);
        check("sw_f3_illegal", out_illegal, 1'b1);
        check("sw_f3_dmem_write", out_ctrl.dmem_write, 1'b0);

        // MUL x1,x2,x3
        offer(32'h023100B3, 32'h408);
        check("mul_illegal", out_illegal, !MEXT);
        check("mul_reg_write", out_ctrl.reg_write, MEXT);
        drain();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            cycle(f);
        end
        flush = 1'b0;
        drain();

        // Reset while entries are held and an input is on offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFC12283; in_pc = 32'h500; cycle(f);
        in_pc     = 32'h504; cycle(f);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_imm", out_imm, '0);
        q.delete();
        started  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(f);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_valid_after", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
